regfile_wr_decoder: RTL and testbench

//   Parametrised ADDR_W-to-2^ADDR_W write-select decoder for the register file.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wr_decoder_if.sv | 25 ++
 rtl/decoder_n_to_2n.sv | 15 +
 rtl/regfile_wr_decoder.sv | 95 +++++++++
 tb/tb_regfile_wr_decoder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and the one-hot helper for the register-file write-select decoder.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_OUT    = 1 << MAX_ADDR_W;

  // Widest-case one-hot; callers truncate to their own output width.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr,
                                                input logic                  act_high);
    logic [MAX_OUT-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return act_high ? vec : ~vec;
  endfunction

endpackage

// File: rtl/regfile_wr_decoder_if.sv
// Request/response bundle between register-file control logic and the write-select decoder.
interface regfile_wr_decoder_if #(
  parameter int ADDR_W = 3
);
  localparam int NUM_OUT = 1 << ADDR_W;

  logic                ENABLE;
  logic [ADDR_W-1:0]   usr_input;
  logic                sweep_start;
  logic                busy;
  logic [NUM_OUT-1:0]  Dout;
  logic [ADDR_W-1:0]   sweep_addr;
  logic                sweep_done;

  modport master (
    output ENABLE, usr_input, sweep_start,
    input  busy, Dout, sweep_addr, sweep_done
  );

  modport slave (
    input  ENABLE, usr_input, sweep_start,
    output busy, Dout, sweep_addr, sweep_done
  );

endinterface

// File: rtl/decoder_n_to_2n.sv
// Combinational ADDR_W-to-2^ADDR_W decoder with selectable output polarity.
module decoder_n_to_2n
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter bit ACT_HIGH = 1'b1
) (
  input  logic [ADDR_W-1:0]        addr,
  output logic [(1<<ADDR_W)-1:0]   dout
);
  localparam int NUM_OUT = 1 << ADDR_W;

  assign dout = NUM_OUT'(onehot(MAX_ADDR_W'(addr), ACT_HIGH));

endmodule

// File: rtl/regfile_wr_decoder.sv
// Registered one-hot write-select decoder with a self-timed sweep for register-file init.
module regfile_wr_decoder
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter bit ACT_HIGH = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_decoder_if.slave  bus
);
  localparam int                  NUM_OUT  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   LAST     = ADDR_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0]  INACTIVE = ACT_HIGH ? '0 : '1;

  state_t               state_r, state_nxt;
  logic [ADDR_W-1:0]    cnt_r, cnt_nxt;
  logic [ADDR_W-1:0]    addr_r, addr_nxt;
  logic [NUM_OUT-1:0]   dout_r, dout_nxt;
  logic                 busy_r;
  logic                 done_r;
  logic [NUM_OUT-1:0]   dec_usr;
  logic [NUM_OUT-1:0]   dec_cnt;

  decoder_n_to_2n #(.ADDR_W(ADDR_W), .ACT_HIGH(ACT_HIGH)) u_dec_usr (
    .addr (bus.usr_input),
    .dout (dec_usr)
  );

  decoder_n_to_2n #(.ADDR_W(ADDR_W), .ACT_HIGH(ACT_HIGH)) u_dec_cnt (
    .addr (cnt_r),
    .dout (dec_cnt)
  );

  // Next state and next output values; a sweep request pre-empts a same-cycle decode.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    addr_nxt  = addr_r;
    dout_nxt  = INACTIVE;
    case (state_r)
      IDLE: begin
        if (bus.sweep_start) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end else if (bus.ENABLE) begin
          dout_nxt = dec_usr;
        end else begin
          dout_nxt = INACTIVE;
        end
      end
      SWEEP: begin
        dout_nxt = dec_cnt;
        addr_nxt = cnt_r;
        cnt_nxt  = cnt_r + ADDR_W'(1);
        if (cnt_r == LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SWEEP;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and output registers; busy/done lag the state by one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      addr_r  <= '0;
      dout_r  <= INACTIVE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      addr_r  <= addr_nxt;
      dout_r  <= dout_nxt;
      busy_r  <= (state_r != IDLE);
      done_r  <= (state_r == DONE);
    end
  end

  assign bus.Dout       = dout_r;
  assign bus.busy       = busy_r;
  assign bus.sweep_addr = addr_r;
  assign bus.sweep_done = done_r;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Directed bench: 3-bit active-high decoder plus a 4-bit active-low instance.
module tb_regfile_wr_decoder;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  regfile_wr_decoder_if #(.ADDR_W(3)) bus_a ();
  regfile_wr_decoder_if #(.ADDR_W(4)) bus_b ();

  regfile_wr_decoder #(.ADDR_W(3), .ACT_HIGH(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  regfile_wr_decoder #(.ADDR_W(4), .ACT_HIGH(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  tab_a [8];
  logic [15:0] tab_b [16];

  initial begin
    n_vec = 0;
    n_err = 0;
    tab_a = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    tab_b = '{16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F,
              16'hFEFF, 16'hFDFF, 16'hFBFF, 16'hF7FF, 16'hEFFF, 16'hDFFF, 16'hBFFF, 16'h7FFF};
    reset = 1'b1;
    bus_a.ENABLE = 1'b0; bus_a.usr_input = 3'd0; bus_a.sweep_start = 1'b0;
    bus_b.ENABLE = 1'b0; bus_b.usr_input = 4'd0; bus_b.sweep_start = 1'b0;

    // reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_dout", 32'(bus_a.Dout), 32'h00);
      check("rst_busy", 32'(bus_a.busy), 32'h0);
      check("rst_done", 32'(bus_a.sweep_done), 32'h0);
      check("rst_addr", 32'(bus_a.sweep_addr), 32'h0);
      check("rstb_dout", 32'(bus_b.Dout), 32'hFFFF);
    end
    reset = 1'b0;

    // normal decode, latency 1
    for (int i = 0; i < 8; i++) begin
      bus_a.ENABLE = 1'b1;
      bus_a.usr_input = 3'(i);
      step();
      check("dec", 32'(bus_a.Dout), 32'(tab_a[i]));
      check("dec_busy", 32'(bus_a.busy), 32'h0);
    end
    bus_a.ENABLE = 1'b0;
    step();
    check("dec_off", 32'(bus_a.Dout), 32'h00);

    // full sweep
    bus_a.sweep_start = 1'b1;
    step();
    bus_a.sweep_start = 1'b0;
    check("sw_entry_dout", 32'(bus_a.Dout), 32'h00);
    check("sw_entry_busy", 32'(bus_a.busy), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("sw_dout", 32'(bus_a.Dout), 32'(tab_a[k]));
      check("sw_addr", 32'(bus_a.sweep_addr), 32'(k));
      check("sw_busy", 32'(bus_a.busy), 32'h1);
      check("sw_done", 32'(bus_a.sweep_done), 32'h0);
    end
    step();
    check("sw_fin_dout", 32'(bus_a.Dout), 32'h00);
    check("sw_fin_busy", 32'(bus_a.busy), 32'h1);
    check("sw_fin_done", 32'(bus_a.sweep_done), 32'h1);
    step();
    check("sw_idle_busy", 32'(bus_a.busy), 32'h0);
    check("sw_idle_done", 32'(bus_a.sweep_done), 32'h0);
    check("sw_idle_dout", 32'(bus_a.Dout), 32'h00);

    // sweep beats same-cycle ENABLE; requests mid-sweep ignored
    bus_a.sweep_start = 1'b1;
    bus_a.ENABLE = 1'b1;
    bus_a.usr_input = 3'd5;
    step();
    check("race_dout", 32'(bus_a.Dout), 32'h00);
    for (int k = 0; k < 8; k++) begin
      bus_a.sweep_start = k[0];
      step();
      check("race_sw_dout", 32'(bus_a.Dout), 32'(tab_a[k]));
    end
    bus_a.sweep_start = 1'b0;
    bus_a.ENABLE = 1'b0;
    step();
    check("race_done", 32'(bus_a.sweep_done), 32'h1);
    check("race_done_dout", 32'(bus_a.Dout), 32'h00);
    step();
    check("race_idle_busy", 32'(bus_a.busy), 32'h0);

    // reset mid-sweep at index 4
    bus_a.sweep_start = 1'b1;
    step();
    bus_a.sweep_start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mid_addr", 32'(bus_a.sweep_addr), 32'h4);
    check("mid_dout", 32'(bus_a.Dout), 32'h10);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_dout", 32'(bus_a.Dout), 32'h00);
    check("mid_rst_busy", 32'(bus_a.busy), 32'h0);
    check("mid_rst_done", 32'(bus_a.sweep_done), 32'h0);
    step();
    check("mid_post_done", 32'(bus_a.sweep_done), 32'h0);
    check("mid_post_busy", 32'(bus_a.busy), 32'h0);
    bus_a.sweep_start = 1'b1;
    step();
    bus_a.sweep_start = 1'b0;
    step();
    check("restart_dout", 32'(bus_a.Dout), 32'h01);
    check("restart_addr", 32'(bus_a.sweep_addr), 32'h0);
    for (int k = 0; k < 9; k++) step();
    check("restart_idle", 32'(bus_a.busy), 32'h0);

    // active-low, 4-bit instance
    check("b_idle_dout", 32'(bus_b.Dout), 32'hFFFF);
    bus_b.ENABLE = 1'b1;
    bus_b.usr_input = 4'd3;
    step();
    bus_b.ENABLE = 1'b0;
    check("b_dec3", 32'(bus_b.Dout), 32'hFFF7);
    bus_b.sweep_start = 1'b1;
    step();
    bus_b.sweep_start = 1'b0;
    check("b_entry_dout", 32'(bus_b.Dout), 32'hFFFF);
    for (int k = 0; k < 16; k++) begin
      step();
      check("b_sw_dout", 32'(bus_b.Dout), 32'(tab_b[k]));
      check("b_sw_busy", 32'(bus_b.busy), 32'h1);
    end
    step();
    check("b_fin_dout", 32'(bus_b.Dout), 32'hFFFF);
    check("b_fin_done", 32'(bus_b.sweep_done), 32'h1);
    check("b_fin_busy", 32'(bus_b.busy), 32'h1);
    step();
    check("b_idle_busy", 32'(bus_b.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
